// File: rtl/dso_acq_ctrl.sv
// dso_acq_ctrl: acquisition/readout sequencer for the DSO capture path.
// It gates capture, waits for a trigger (or an auto-mode timeout), then streams
// the NPTS-sample wave RAM into the display line buffer. After the last write
// lands, it pulses ram_rd_over so the store can re-arm.
// Optional build macro: DSO_FRAME_CNT_EN adds a saturating frame_cnt output.
module dso_acq_ctrl #(
  parameter int          NPTS     = 300,
  parameter int          RD_LAT   = 1,
  parameter logic [23:0] AUTO_TMO = 24'd5_000_000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [1:0]  trig_mode,
  input  logic        run_key,
  input  logic        single_key,
  input  logic        vsync,
  input  logic        wave_ready,
  input  logic [7:0]  wave_rd_data,
  output logic        wave_run,
  output logic        ram_rd_en,
  output logic [9:0]  wave_rd_addr,
  output logic        ram_rd_over,
  output logic        pix_we,
  output logic [8:0]  pix_addr,
  output logic [7:0]  pix_data,
  output logic        forced,
`ifdef DSO_FRAME_CNT_EN
  output logic [15:0] frame_cnt,
`endif
  output logic [2:0]  acq_state
);

  typedef enum logic [2:0] {
    ST_STOP  = 3'd0,
    ST_ARM   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_READ  = 3'd3,
    ST_FLUSH = 3'd4,
    ST_HOLD  = 3'd5
  } state_t;

  state_t              r_state, w_nxt;
  logic                r_run;       // continuous-run flag; cleared by a stop request
  logic                r_single;    // one-shot armed from single_key
  logic [1:0]          r_mode;      // trig_mode captured at ARM
  logic [23:0]         r_tmo;
  logic [9:0]          r_addr;
  logic                r_forced;
  logic [RD_LAT:1]     r_vld_pipe;  // read-enable delayed to match RAM latency
  logic [RD_LAT:1][8:0] r_addr_pipe;

  logic w_rd_en, w_last, w_tmo_hit, w_flush_done, w_to_stop;

  assign w_rd_en      = (r_state == ST_READ);
  assign w_last       = (r_addr == 10'(NPTS - 1));
  // Timeout looks at the live mode; a single-shot always waits for a real trigger.
  assign w_tmo_hit    = (trig_mode == 2'd0) && !r_single && (r_tmo >= AUTO_TMO - 24'd1);
  // Done once no pipelined write is still in flight.
  assign w_flush_done = (r_state == ST_FLUSH) && !(|r_vld_pipe);
  assign w_to_stop    = !r_run || r_single || (r_mode == 2'd2) || run_key;

  // Next-state decode
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      ST_STOP:  if (single_key || run_key) w_nxt = ST_ARM;
      ST_ARM:   w_nxt = run_key ? ST_STOP : ST_WAIT;
      ST_WAIT:  if (run_key) w_nxt = ST_STOP;
                else if (wave_ready || w_tmo_hit) w_nxt = ST_READ;
      ST_READ:  if (w_last) w_nxt = ST_FLUSH;
      ST_FLUSH: if (w_flush_done) w_nxt = w_to_stop ? ST_STOP : ST_HOLD;
      ST_HOLD:  if (run_key) w_nxt = ST_STOP;
                else if (vsync) w_nxt = ST_ARM;
      default:  w_nxt = ST_STOP;
    endcase
  end

  // State register and sequencing flags/counters
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= ST_STOP;
      r_run    <= 1'b0;
      r_single <= 1'b0;
      r_mode   <= 2'd0;
      r_tmo    <= 24'd0;
      r_addr   <= 10'd0;
      r_forced <= 1'b0;
    end else begin
      r_state <= w_nxt;
      case (r_state)
        ST_STOP: begin
          if (single_key)   r_single <= 1'b1;   // single wins over run
          else if (run_key) r_run    <= 1'b1;
        end
        ST_ARM: begin
          r_tmo  <= 24'd0;
          r_mode <= trig_mode;
        end
        ST_WAIT: begin
          if (r_tmo != 24'hFF_FFFF) r_tmo <= r_tmo + 24'd1;
          if (w_nxt == ST_READ) r_forced <= !wave_ready;
        end
        ST_READ: begin
          r_addr <= w_last ? 10'd0 : r_addr + 10'd1;
          if (run_key) r_run <= 1'b0;           // stop after this readout
        end
        ST_FLUSH: if (run_key) r_run <= 1'b0;
        default: ;
      endcase
      if (r_state != ST_STOP && w_nxt == ST_STOP) begin
        r_run    <= 1'b0;
        r_single <= 1'b0;
      end
    end
  end

  // Delay read enable/address by RD_LAT to align with RAM data
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_vld_pipe  <= '0;
      r_addr_pipe <= '0;
    end else begin
      r_vld_pipe[1]  <= w_rd_en;
      r_addr_pipe[1] <= r_addr[8:0];
      for (int i = 2; i <= RD_LAT; i++) begin
        r_vld_pipe[i]  <= r_vld_pipe[i-1];
        r_addr_pipe[i] <= r_addr_pipe[i-1];
      end
    end
  end

`ifdef DSO_FRAME_CNT_EN
  logic [15:0] r_frame_cnt;
  // Saturating count of completed readouts; cleared when a single-shot is accepted
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                                    r_frame_cnt <= 16'd0;
    else if (r_state == ST_STOP && single_key)    r_frame_cnt <= 16'd0;
    else if (w_flush_done && r_frame_cnt != 16'hFFFF) r_frame_cnt <= r_frame_cnt + 16'd1;
  end
  assign frame_cnt = r_frame_cnt;
`endif

  assign wave_run     = (r_state == ST_ARM) || (r_state == ST_WAIT);
  assign ram_rd_en    = w_rd_en;
  assign wave_rd_addr = r_addr;
  assign ram_rd_over  = w_flush_done;
  assign pix_we       = r_vld_pipe[RD_LAT];
  assign pix_addr     = r_addr_pipe[RD_LAT];
  assign pix_data     = pix_we ? wave_rd_data : 8'h00;
  assign forced       = r_forced;
  assign acq_state    = r_state;

endmodule

// File: tb/tb_dso_acq_ctrl.sv
// Directed bench for dso_acq_ctrl: RD_LAT=1 instance for run/auto/single/stop/reset
// scenarios, RD_LAT=3 instance for alignment and frame counting.
module tb_dso_acq_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstn, rstn3, run_key, single_key, vsync, wave_ready;
  logic [1:0] trig_mode;
  logic [7:0] rd1, rd3, r3a, r3b;

  logic       wr1, en1, over1, we1, frc1;
  logic [9:0] a1;
  logic [8:0] pa1;
  logic [7:0] pd1;
  logic [2:0] st1;
  logic       wr3, en3, over3, we3, frc3;
  logic [9:0] a3;
  logic [8:0] pa3;
  logic [7:0] pd3;
  logic [2:0] st3;
`ifdef DSO_FRAME_CNT_EN
  logic [15:0] fc1, fc3;
`endif

  dso_acq_ctrl #(.NPTS(300), .RD_LAT(1), .AUTO_TMO(24'd1000)) u_dut (
    .clk(clk), .rstn(rstn), .trig_mode(trig_mode), .run_key(run_key),
    .single_key(single_key), .vsync(vsync), .wave_ready(wave_ready),
    .wave_rd_data(rd1), .wave_run(wr1), .ram_rd_en(en1), .wave_rd_addr(a1),
    .ram_rd_over(over1), .pix_we(we1), .pix_addr(pa1), .pix_data(pd1),
    .forced(frc1),
`ifdef DSO_FRAME_CNT_EN
    .frame_cnt(fc1),
`endif
    .acq_state(st1));

  dso_acq_ctrl #(.NPTS(300), .RD_LAT(3), .AUTO_TMO(24'd1000)) u_dut3 (
    .clk(clk), .rstn(rstn3), .trig_mode(trig_mode), .run_key(run_key),
    .single_key(single_key), .vsync(vsync), .wave_ready(wave_ready),
    .wave_rd_data(rd3), .wave_run(wr3), .ram_rd_en(en3), .wave_rd_addr(a3),
    .ram_rd_over(over3), .pix_we(we3), .pix_addr(pa3), .pix_data(pd3),
    .forced(frc3),
`ifdef DSO_FRAME_CNT_EN
    .frame_cnt(fc3),
`endif
    .acq_state(st3));

  function automatic logic [7:0] ramf(input logic [9:0] a);
    logic [15:0] t;
    t = {6'b0, a} * 16'd7 + 16'd3;
    return t[7:0];
  endfunction

  // Wave RAM models: latency 1 and latency 3
  always @(posedge clk) begin
    rd1 <= ramf(a1);
    r3a <= ramf(a3);
    r3b <= r3a;
    rd3 <= r3b;
  end

  logic sel3 = 1'b0;
  logic       m_en, m_over, m_we, m_wr, m_frc;
  logic [9:0] m_a;
  logic [8:0] m_pa;
  logic [7:0] m_pd;
  logic [2:0] m_st;
  assign m_en   = sel3 ? en3   : en1;
  assign m_over = sel3 ? over3 : over1;
  assign m_we   = sel3 ? we3   : we1;
  assign m_wr   = sel3 ? wr3   : wr1;
  assign m_frc  = sel3 ? frc3  : frc1;
  assign m_a    = sel3 ? a3    : a1;
  assign m_pa   = sel3 ? pa3   : pa1;
  assign m_pd   = sel3 ? pd3   : pd1;
  assign m_st   = sel3 ? st3   : st1;

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Readout monitor, sampled on the falling edge
  logic mon_on = 1'b0;
  int rd_cnt, we_cnt, over_cnt, addr_bad, data_bad, lag_bad;
  logic [9:0] exp_a;
  logic [8:0] exp_p;
  logic [3:0] en_hist;
  task automatic mon_clear();
    rd_cnt = 0; we_cnt = 0; over_cnt = 0; addr_bad = 0; data_bad = 0; lag_bad = 0;
    exp_a = '0; exp_p = '0; en_hist = '0;
  endtask
  always @(negedge clk) if (mon_on) begin
    if (m_en) begin
      if (m_a != exp_a) addr_bad++;
      exp_a++; rd_cnt++;
    end
    if (m_we) begin
      if (m_pa != exp_p || m_pd != ramf({1'b0, m_pa})) data_bad++;
      exp_p++; we_cnt++;
    end
    if (m_we != en_hist[sel3 ? 2 : 0]) lag_bad++;
    en_hist = {en_hist[2:0], m_en};
    if (m_over) begin over_cnt++; exp_a = '0; exp_p = '0; end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask
  task automatic pulse_run();    run_key = 1'b1;    step(); run_key = 1'b0;    endtask
  task automatic pulse_single(); single_key = 1'b1; step(); single_key = 1'b0; endtask
  task automatic pulse_vsync();  vsync = 1'b1;      step(); vsync = 1'b0;      endtask
  task automatic wait_st(input logic [2:0] s, input int max, input string tag);
    int n = 0;
    while (m_st != s && n < max) begin step(); n++; end
    chk(tag, 32'(m_st), 32'(s));
  endtask
  task automatic wait_addr(input logic [9:0] a, input string tag);
    int n = 0;
    while (m_a != a && n < 400) begin step(); n++; end
    chk(tag, 32'(m_a), 32'(a));
  endtask
  // ARM -> WAIT -> trigger -> READ
  task automatic trigger();
    step();
    wave_ready = 1'b1; step(); wave_ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rstn = 1'b0; rstn3 = 1'b0; run_key = 1'b0; single_key = 1'b0; vsync = 1'b0;
    wave_ready = 1'b0; trig_mode = 2'd1;
    mon_clear();
    repeat (3) step();
    chk("rst_state", 32'(st1), 0);
    chk("rst_outs", {27'b0, wr1, en1, we1, over1, frc1}, 0);
    rstn = 1'b1; step();
    chk("rst_idle", 32'(st1), 0);

    // 1: normal mode frame
    mon_on = 1'b1;
    pulse_run();
    chk("t1_arm", {29'b0, m_st}, 1);
    chk("t1_wave_run", 32'(m_wr), 1);
    step();
    chk("t1_wait", 32'(m_st), 2);
    repeat (99) step();
    mon_clear();
    wave_ready = 1'b1; step(); wave_ready = 1'b0;
    chk("t1_read_lat", {30'b0, m_en, ~m_wr}, 3);
    chk("t1_first_addr", 32'(m_a), 0);
    wait_st(3'd5, 400, "t1_hold");
    chk("t1_rd_cnt", rd_cnt, 300);
    chk("t1_addr_bad", addr_bad, 0);
    chk("t1_we_cnt", we_cnt, 300);
    chk("t1_data_bad", data_bad, 0);
    chk("t1_lag_bad", lag_bad, 0);
    chk("t1_over_cnt", over_cnt, 1);
    chk("t1_forced", 32'(m_frc), 0);
    repeat (5) step();
    chk("t1_still_hold", 32'(m_st), 5);
    pulse_vsync();
    chk("t1_rearm", 32'(m_st), 1);
    pulse_run();
    chk("t1_stop_arm", 32'(m_st), 0);

    // 2: auto mode timeout
    trig_mode = 2'd0;
    pulse_run(); step();
    chk("t2_wait", 32'(m_st), 2);
    mon_clear();
    n = 0;
    while (m_st != 3'd3 && n < 1100) begin step(); n++; end
    chk("t2_tmo_cycles", n, 1000);
    chk("t2_forced", 32'(m_frc), 1);
    chk("t2_wave_run", 32'(m_wr), 0);
    wait_st(3'd5, 400, "t2_hold");
    chk("t2_rd_cnt", rd_cnt, 300);
    pulse_run();
    chk("t2_stop_hold", 32'(m_st), 0);

    // 3: single shot, both keys together (single wins)
    trig_mode = 2'd1;
    mon_clear();
    run_key = 1'b1; pulse_single(); run_key = 1'b0;
    chk("t3_arm", 32'(m_st), 1);
    trigger();
    chk("t3_read", 32'(m_st), 3);
    wait_st(3'd0, 400, "t3_stop");
    chk("t3_rd_cnt", rd_cnt, 300);
    chk("t3_over_cnt", over_cnt, 1);
    chk("t3_wave_run", 32'(m_wr), 0);
    pulse_vsync(); repeat (3) step();
    chk("t3_no_rearm", 32'(m_st), 0);

    // 4: stop in WAIT, then stop mid-READ
    pulse_run(); step();
    pulse_run();
    chk("t4_wait_stop", {28'b0, m_st, m_wr}, 0);
    mon_clear();
    pulse_run(); trigger();
    wait_addr(10'd150, "t4_addr150");
    pulse_run();
    wait_st(3'd0, 400, "t4_stop");
    chk("t4_rd_cnt", rd_cnt, 300);
    chk("t4_addr_bad", addr_bad, 0);
    chk("t4_over_cnt", over_cnt, 1);

    // 5: reset mid-READ
    mon_clear();
    pulse_run(); trigger();
    wait_addr(10'd200, "t5_addr200");
    #2 rstn = 1'b0;
    #1 chk("t5_async_outs", {28'b0, wr1, en1, we1, over1}, 0);
    step(); step();
    rstn = 1'b1; step();
    chk("t5_state", 32'(st1), 0);
    chk("t5_over_cnt", over_cnt, 0);

    // 6: RD_LAT=3 instance, three normal frames
    rstn = 1'b0; rstn3 = 1'b1; sel3 = 1'b1;
    step();
    mon_clear();
    pulse_run();
    for (int f = 0; f < 3; f++) begin
      trigger();
      wait_st(3'd5, 400, "t6_hold");
      if (f < 2) pulse_vsync();
    end
    chk("t6_rd_cnt", rd_cnt, 900);
    chk("t6_we_cnt", we_cnt, 900);
    chk("t6_lag_bad", lag_bad, 0);
    chk("t6_data_bad", data_bad, 0);
    chk("t6_over_cnt", over_cnt, 3);
`ifdef DSO_FRAME_CNT_EN
    chk("t6_frame_cnt", 32'(fc3), 3);
`endif
    mon_on = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/dso_acq_ctrl.md
Name: dso_acq_ctrl

Overview:
Acquisition/readout sequencer for the DSO capture path, in the `clk` domain.
- Gates capture via `wave_run` and handles run/stop and trigger modes (auto/normal/single).
- When the capture store reports a full frame, reads the 300-sample wave RAM into the display line buffer, then pulses `ram_rd_over` to release the store for re-arm.
- Re-arm is rate-limited to one frame per display `vsync`.

Parameters:
- NPTS, 300, samples per frame read (addresses 0..NPTS-1).
- RD_LAT, 1, wave RAM read latency in clk cycles (1..3).
- AUTO_TMO, 24'd5_000_000, clk cycles to wait for a trigger in auto mode before forcing a readout.

Ports:
- clk  in  1  system clock (also drives the RAM read port).
- rstn  in  1  asynchronous active-low reset.
- trig_mode  in  2  0=auto, 1=normal, 2=single, 3=treated as normal.
- run_key  in  1  one-cycle pulse; toggles run/stop.
- single_key  in  1  one-cycle pulse; arms one single-shot capture.
- vsync  in  1  one-cycle pulse per display frame.
- wave_ready  in  1  level from the capture store; frame captured and readable.
- wave_rd_data  in  8  RAM read data.
- wave_run  out  1  capture enable to the store.
- ram_rd_en  out  1  RAM read enable.
- wave_rd_addr  out  10  RAM read address.
- ram_rd_over  out  1  one-cycle pulse; readout complete.
- pix_we  out  1  line-buffer write strobe.
- pix_addr  out  9  line-buffer address.
- pix_data  out  8  line-buffer data.
- forced  out  1  last frame was an auto-timeout (untriggered) frame.
- acq_state  out  3  current FSM state encoding.

Behaviour:
- Reset: all outputs 0, state STOP, `run` flag 0, timeout counter 0.
- FSM states and encodings: STOP=0, ARM=1, WAIT=2, READ=3, FLUSH=4, HOLD=5.
- STOP:
  - `run_key` -> run=1, go to ARM.
  - `single_key` -> go to ARM with single flag set, regardless of `trig_mode`.
- ARM: `wave_run`=1, timeout counter cleared; next cycle go to WAIT.
- WAIT: `wave_run`=1; timeout counter increments each cycle.
  - `wave_ready`=1 -> READ, `forced`<=0.
  - trig_mode=0 and counter reaches AUTO_TMO-1 -> READ, `forced`<=1.
  - Normal and single modes never time out.
- READ:
  - `wave_run`=0 on the first READ cycle.
  - `ram_rd_en`=1 for exactly NPTS consecutive cycles; `wave_rd_addr` = 0,1,...,NPTS-1, one per cycle.
  - Then go to FLUSH.
- Data alignment:
  - `pix_we`, `pix_addr` and `pix_data` are `ram_rd_en`/address delayed by exactly RD_LAT cycles, with `pix_data`=`wave_rd_data`.
  - `pix_addr` is the low 9 bits of the delayed address.
- FLUSH: wait until the last `pix_we` has occurred.
  - The following cycle pulses `ram_rd_over` for 1 cycle.
  - Go to STOP if the single flag is set (flag cleared, run<=0), else HOLD.
- HOLD: wait for `vsync` -> ARM. A `vsync` coincident with FLUSH exit is not counted.
- `run_key` behaviour:
  - In ARM/WAIT/HOLD: run<=0, go to STOP immediately, `wave_run`<=0 next cycle.
  - In READ/FLUSH: the stop is latched; the readout completes (`ram_rd_over` still pulses), then go to STOP.
- `single_key` while running: ignored.
- `trig_mode` is sampled at every ARM. A change mid-WAIT takes effect at the next ARM, except that the timeout check uses the live value.
- Simultaneous `run_key` and `single_key` in STOP: `single_key` wins.
- Reset mid-READ: outputs return to 0 asynchronously; no `ram_rd_over` is issued.
- Latency from `wave_ready` rising in WAIT to first `ram_rd_en`: 1 cycle.
- Counters: address counter 10 bits, never exceeds NPTS-1. Timeout counter 24 bits, saturating.

Optional Feature:
- Macro: `DSO_FRAME_CNT_EN`.
- Defined: adds output `frame_cnt` [15:0].
  - Reset 0; increments by 1 on each `ram_rd_over` pulse.
  - Saturates at 16'hFFFF.
  - Cleared on `single_key` accepted in STOP.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
1. Normal mode: `run_key`, `wave_ready` high after 100 cycles.
   - Required: `ram_rd_en` high for exactly 300 cycles, addresses 0..299.
   - Required: `pix_we` lags by RD_LAT=1, 300 writes with `pix_data` matching the RAM model.
   - Required: one `ram_rd_over` pulse, `forced`=0, then HOLD until `vsync`.
2. Auto mode with AUTO_TMO=1000, `wave_ready` held 0.
   - Required: READ entered exactly 1000 cycles after WAIT entry, `forced`=1, `wave_run` drops on READ entry.
3. Single mode: `single_key`, `wave_ready`.
   - Required: one readout, `ram_rd_over` pulse, state returns to STOP (0), `wave_run`=0.
   - Required: a further `vsync` causes no re-arm.
4. `run_key` at address 150 during READ.
   - Required: readout continues to address 299, `ram_rd_over` pulses, then STOP.
   - Required: `run_key` in WAIT gives STOP next cycle with `wave_run`=0.
5. `rstn` asserted at address 200.
   - Required: `ram_rd_en`, `pix_we`, `wave_run`, `ram_rd_over` all 0 asynchronously; state=STOP after release.
6. RD_LAT=3 build with `DSO_FRAME_CNT_EN` defined, 3 normal frames.
   - Required: `pix_we` lags `ram_rd_en` by 3 cycles, `frame_cnt`=3.
